// File: rtl/sl_receiver.sv
// sl_receiver: two-wire SL line receiver.
//
// Samples the asynchronous SL0/SL1 lines through 2-flop synchronizers. It
// decodes bit-0, bit-1 and stop events, checks odd parity and word length,
// and presents each completed word in a holding register. The register
// file/bus side takes the word with a valid/ack handshake.
//
// Optional feature macro: SL_RX_TIMEOUT_EN
//   When defined, a 16-bit stall counter aborts a word whose line code has
//   not changed for TIMEOUT_CYCLES cycles while the receiver is busy.
//   When undefined, a stalled word waits indefinitely.
//
// Ports:
//   clk           in   single clock domain
//   rst           in   synchronous active-high reset
//   SL0, SL1      in   asynchronous line inputs, idle high
//   cfg_len[5:0]  in   expected word length L (parity included)
//   cfg_wr        in   load cfg_len into L on this edge
//   rx_ack        in   consumer has taken the held word
//   rx_data[31:0] out  data bits, right-aligned, MSB received first
//   rx_bit_count  out  bits received including parity
//   rx_parity_ok  out  odd parity over all received bits
//   rx_len_err    out  bit count differs from L
//   rx_proto_err  out  an aborted word preceded this one
//   rx_valid      out  holding register full
//   rx_overrun    out  sticky: a completed word was dropped
//   rx_busy       out  a word is in progress
module sl_receiver #(
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SL0,
  input  logic        SL1,
  input  logic [5:0]  cfg_len,
  input  logic        cfg_wr,
  input  logic        rx_ack,
  output logic [31:0] rx_data,
  output logic [5:0]  rx_bit_count,
  output logic        rx_parity_ok,
  output logic        rx_len_err,
  output logic        rx_proto_err,
  output logic        rx_valid,
  output logic        rx_overrun,
  output logic        rx_busy
);

  if (MAX_LEN < 8 || MAX_LEN > 32) begin : g_bad_max_len
    $error("sl_receiver: MAX_LEN must be in 8..32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sl_receiver: TIMEOUT_CYCLES must fit the 16-bit stall counter");
  end

  localparam logic [5:0] LEN_MAX6 = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT0,
    ST_BIT1,
    ST_STOP,
    ST_ERR
  } state_t;

  function automatic logic odd_parity(input logic [32:0] v);
    return ^v;
  endfunction

  // Synchronizer registers.
  logic        r_sl0_p0, r_sl0_p1;
  logic        r_sl1_p0, r_sl1_p1;
  logic [1:0]  w_code;

  state_t      r_state, w_state_nx;
  logic [32:0] r_shift, w_shift_nx;
  logic [5:0]  r_count, w_count_nx;
  logic [5:0]  r_len;
  logic        w_complete;
  logic        w_discard;
  logic        w_timeout;
  logic        r_err_pend;

  logic [31:0] r_data;
  logic [5:0]  r_bit_count;
  logic        r_parity_ok;
  logic        r_len_err;
  logic        r_proto_err;
  logic        r_valid;
  logic        r_overrun;
  logic        r_busy;

  // {s0,s1}: bit 1 is line 0, bit 0 is line 1.
  assign w_code = {r_sl0_p1, r_sl1_p1};

`ifdef SL_RX_TIMEOUT_EN
  logic [15:0] r_stall;
  logic [1:0]  r_code_d;

  assign w_timeout = r_busy && (r_stall == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall  <= 16'd0;
      r_code_d <= 2'b11;
    end else begin
      r_code_d <= w_code;
      // Any line change, an idle receiver, or a fired timeout restarts the count.
      if (!r_busy || (w_code != r_code_d) || w_timeout) begin
        r_stall <= 16'd0;
      end else begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and shift/count decode.
  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_count_nx = r_count;
    w_complete = 1'b0;
    w_discard  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        case (w_code)
          2'b01, 2'b10: begin
            if (r_count >= LEN_MAX6) begin
              // One pulse beyond the maximum word length is an overflow.
              w_state_nx = ST_ERR;
              w_discard  = 1'b1;
            end else begin
              w_state_nx = (w_code == 2'b10) ? ST_BIT1 : ST_BIT0;
              w_shift_nx = {r_shift[31:0], w_code[1]};
              w_count_nx = r_count + 6'd1;
            end
          end
          2'b00: begin
            // A stop with no bits is swallowed silently.
            w_state_nx = ST_STOP;
            w_complete = (r_count != 6'd0);
          end
          default: ;
        endcase
      end
      ST_BIT0: begin
        if (w_code == 2'b11) begin
          w_state_nx = ST_IDLE;
        end else if (w_code != 2'b01) begin
          w_state_nx = ST_ERR;
          w_discard  = 1'b1;
        end
      end
      ST_BIT1: begin
        if (w_code == 2'b11) begin
          w_state_nx = ST_IDLE;
        end else if (w_code != 2'b10) begin
          w_state_nx = ST_ERR;
          w_discard  = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_code == 2'b11) begin
          w_state_nx = ST_IDLE;
        end else if (w_code != 2'b00) begin
          w_state_nx = ST_ERR;
          w_discard  = 1'b1;
        end
      end
      ST_ERR: begin
        if (w_code == 2'b11) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    // A stall abort takes priority over whatever the line decode wanted.
    if (w_timeout) begin
      w_state_nx = ST_ERR;
      w_discard  = 1'b1;
      w_complete = 1'b0;
    end

    if (w_discard || w_complete) begin
      w_shift_nx = 33'd0;
      w_count_nx = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sl0_p0    <= 1'b1;
      r_sl0_p1    <= 1'b1;
      r_sl1_p0    <= 1'b1;
      r_sl1_p1    <= 1'b1;
      r_state     <= ST_IDLE;
      r_shift     <= 33'd0;
      r_count     <= 6'd0;
      r_len       <= 6'd8;
      r_err_pend  <= 1'b0;
      r_data      <= 32'd0;
      r_bit_count <= 6'd0;
      r_parity_ok <= 1'b0;
      r_len_err   <= 1'b0;
      r_proto_err <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Stage p0 -> p1: metastability settling on each line.
      r_sl0_p0 <= SL0;
      r_sl0_p1 <= r_sl0_p0;
      r_sl1_p0 <= SL1;
      r_sl1_p1 <= r_sl1_p0;

      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_count <= w_count_nx;
      r_busy  <= (w_state_nx != ST_IDLE) || (w_count_nx != 6'd0);

      if (cfg_wr) begin
        r_len <= cfg_len;
      end

      if (w_discard) begin
        r_err_pend <= 1'b1;
      end else if (w_complete) begin
        r_err_pend <= 1'b0;
      end

      // Holding register: an ack in the completion cycle frees room for the new word.
      if (w_complete) begin
        if (!r_valid || rx_ack) begin
          r_data      <= r_shift[32:1];
          r_bit_count <= r_count;
          r_parity_ok <= odd_parity(r_shift);
          r_len_err   <= (r_count != r_len);
          r_proto_err <= r_err_pend;
          r_valid     <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data      = r_data;
  assign rx_bit_count = r_bit_count;
  assign rx_parity_ok = r_parity_ok;
  assign rx_len_err   = r_len_err;
  assign rx_proto_err = r_proto_err;
  assign rx_valid     = r_valid;
  assign rx_overrun   = r_overrun;
  assign rx_busy      = r_busy;

endmodule

// File: doc/sl_receiver.md
# sl_receiver

Synthesizable two-wire SL line receiver, the downstream stage of the SL transmitter. It samples SL0/SL1, decodes bit pulses and stop conditions, checks parity and word length, and presents each word in a holding register with a valid/ack handshake for the register-file/bus side.

## Interface
- `MAX_LEN`, 32: maximum bits per word, including parity. Legal range 8..32.
- `TIMEOUT_CYCLES`, 1024: number of stalled-line cycles inside a word before the word is aborted. Used only with `SL_RX_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `SL0` in 1: line 0, asynchronous, idle high.
- `SL1` in 1: line 1, asynchronous, idle high.
- `cfg_len` in 6: expected word length L, parity bit included.
- `cfg_wr` in 1: loads `cfg_len` on this clock edge.
- `rx_ack` in 1: consumer has taken the word.
- `rx_data` out 32: data bits, right-aligned, MSB received first.
- `rx_bit_count` out 6: total bits received, parity included.
- `rx_parity_ok` out 1: odd parity check passed.
- `rx_len_err` out 1: `rx_bit_count` differs from L.
- `rx_proto_err` out 1: illegal line sequence, overflow, or timeout.
- `rx_valid` out 1: holding register is full.
- `rx_overrun` out 1: sticky; a completed word was dropped while `rx_valid` was high.
- `rx_busy` out 1: a word is in progress.

## Operation
- Line coding:
  - idle = both lines high.
  - bit 0 = SL0 low pulse while SL1 is high.
  - bit 1 = SL1 low pulse while SL0 is high.
  - stop = both lines low, entered from idle.
  - Every pulse returns to idle before the next event.
- Input path: a 2-flop synchronizer per line. Both lines are decoded from the synchronized pair `s0`/`s1`.
- FSM states: IDLE, BIT0, BIT1, STOP, ERR.
  - IDLE → BIT0 on {s0,s1}=01. Shift 0 in, increment the count.
  - IDLE → BIT1 on 10. Shift 1 in, increment the count.
  - IDLE → STOP on 00. Complete the word.
  - BIT0/BIT1 → IDLE on 11.
  - BIT0/BIT1 → ERR on 00 or on the opposite single-low code.
  - STOP → IDLE on 11. STOP → ERR on 01 or 10.
  - ERR → IDLE on 11. The partial word is discarded, `rx_proto_err` is set in the next completed word's status, and no `rx_valid` is raised for the discarded word.
- Shift register: 33 bits, shifts left, new bit into the LSB.
- Bit counter: 6 bits.
  - The 33rd bit pulse moves the FSM to ERR (overflow).
  - A stop with count 0 is ignored: no word is produced and the FSM returns to IDLE.
- Word completion, on stop with count n ≥ 1:
  - `rx_data` = shift register bits [n-1:1], right-aligned, zero-extended.
  - The last received bit is the parity bit.
  - `rx_parity_ok` = XOR of all n bits == 1.
  - `rx_len_err` = (n != L).
- Handshake:
  - Completion while `rx_valid`=0: load the holding register and set `rx_valid`.
  - Completion while `rx_valid`=1: drop the new word and set `rx_overrun`.
  - `rx_ack` with `rx_valid`=1 clears `rx_valid` on the next edge.
  - Ack and completion in the same cycle: the new word is loaded, `rx_valid` stays 1, no overrun.
  - `rx_overrun` clears only on reset.
- `cfg_wr` during a word takes effect immediately. The length check uses the L value current at stop.
- `rx_busy` = 1 when the FSM is not IDLE, or when count > 0.

## Timing
- Reset values:
  - `rx_data`=0, `rx_bit_count`=0.
  - `rx_parity_ok`=0, `rx_len_err`=0, `rx_proto_err`=0.
  - `rx_valid`=0, `rx_overrun`=0, `rx_busy`=0.
  - L=8, FSM in IDLE, synchronizer flops at 1.
- Reset mid-word clears all state. Line activity that is still in progress after reset releases is treated as starting from IDLE; a lone trailing pulse yields a short word flagged with `rx_len_err`.
- Latency: a pin edge reaches `s0`/`s1` after 2 edges. `rx_valid` and status rise 1 edge after the stop code appears on `s0`/`s1`, i.e. 3 cycles after the pin edge.
- Minimum pulse and gap width: 2 clk. Shorter pulses may be missed; this is not detected.
- All outputs are registered.

## Configuration
- `SL_RX_TIMEOUT_EN` defined:
  - A 16-bit stall counter resets on any change of {s0,s1}.
  - It runs while `rx_busy`=1.
  - On reaching `TIMEOUT_CYCLES`, the FSM enters ERR and the partial word is discarded.
  - The following 11 returns the FSM to IDLE.
- `SL_RX_TIMEOUT_EN` undefined: no counter. A stalled word waits indefinitely.

## Test plan
- Send L=9 bits 1010_0101 + parity 1, then stop → `rx_valid`=1, `rx_data`=0x000000A5, `rx_bit_count`=9, `rx_parity_ok`=1, `rx_len_err`=0.
- Send the same word with parity 0 → `rx_parity_ok`=0. Send 10 bits with L=9 → `rx_len_err`=1.
- Send two words without `rx_ack` → first word retained, `rx_overrun`=1. Ack on the stop-detect cycle of word 2 → word 2 loaded, no overrun.
- Drive both lines low during a BIT1 pulse, then send a clean word → bad word dropped, next word has `rx_proto_err`=1. Send 33 pulses → overflow leads to ERR.
- With `SL_RX_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: stall after 3 bits → abort after 16 cycles and `rx_busy`=0.
- Random lengths 8..32 looped against the SL transmitter across all frequency modes → every `rx_data` matches the sent word, `rx_parity_ok`=1.
